// File: rtl/osc_freq_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM state codes
// and the cycle-counter width helper.
package osc_meas_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETTLE  = 2'd1;
  localparam state_t ST_MEASURE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  // One counter serves both the settle and the window phases, so it must hold the larger load.
  function automatic int cyc_cnt_width(input int win_cyc, input int set_cyc);
    return $clog2(((win_cyc > set_cyc) ? win_cyc : set_cyc) + 1);
  endfunction

endpackage

// File: rtl/osc_freq_meter_if.sv
// Consumer-side handshake and result bus of the frequency meter.
interface osc_freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             ack;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (output start, ack, input busy, valid, count, ovf);
  modport slave  (input start, ack, output busy, valid, count, ovf);
endinterface

// File: rtl/osc_edge_sync.sv
// Synchroniser for the asynchronous oscillator output followed by a prev flop;
// emits a one-cycle pulse for each synchronised rising edge.
module osc_edge_sync #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic async_in,
  output logic rise
);
  // Stages 0..SYNC_N-1 form the synchroniser, stage SYNC_N is the prev flop.
  logic [SYNC_N:0] stage_reg;
  // Marks which stages hold genuine post-release samples rather than cleared zeros,
  // so an oscillator already high at release does not read as a rising edge.
  logic [SYNC_N:0] vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
      vld_reg   <= '0;
    end else if (clr) begin
      stage_reg <= '0;
      vld_reg   <= '0;
    end else begin
      stage_reg <= {stage_reg[SYNC_N-1:0], async_in};
      vld_reg   <= {vld_reg[SYNC_N-1:0], 1'b1};
    end
  end

  assign rise = stage_reg[SYNC_N-1] & ~stage_reg[SYNC_N] & vld_reg[SYNC_N];

endmodule

// File: rtl/osc_freq_meter.sv
// Holds the ring oscillator in init, releases it, and counts its rising edges
// over a fixed window of CLK cycles; the count is f_OSC in units of f_CLK/WIN_CYC.
module osc_freq_meter
  import osc_meas_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int WIN_CYC = 1000,
  parameter int SET_CYC = 5,
  parameter int SYNC_N  = 2
) (
  input  logic              CLK,
  input  logic              INIT_n,
  input  logic              OSC_IN,
  output logic              OSC_INIT,
  osc_freq_meter_if.slave   bus
);
  localparam int CYC_W = cyc_cnt_width(WIN_CYC, SET_CYC);
  localparam logic [CYC_W-1:0] WIN_LD  = CYC_W'(WIN_CYC);
  localparam logic [CYC_W-1:0] SET_LD  = CYC_W'(SET_CYC);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg;
  logic [CYC_W-1:0] cyc_reg;
  logic [CNT_W-1:0] edge_reg;
  logic             ovf_flag_reg;
  logic             osc_init_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic             rise;

  osc_edge_sync #(.SYNC_N(SYNC_N)) u_edge_sync (
    .clk      (CLK),
    .rst_n    (INIT_n),
    .clr      (osc_init_reg),
    .async_in (OSC_IN),
    .rise     (rise)
  );

  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      state_reg    <= ST_IDLE;
      cyc_reg      <= '0;
      edge_reg     <= '0;
      ovf_flag_reg <= 1'b0;
      osc_init_reg <= 1'b1;
      valid_reg    <= 1'b0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      // Lower priority than the DONE write below, so a simultaneous ACK loses.
      if (bus.ack) valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg <= ST_SETTLE;
            valid_reg <= 1'b0;
            cyc_reg   <= SET_LD;
          end
        end
        ST_SETTLE: begin
          if (cyc_reg == CYC_ONE) begin
            state_reg    <= ST_MEASURE;
            cyc_reg      <= WIN_LD;
            edge_reg     <= '0;
            ovf_flag_reg <= 1'b0;
            osc_init_reg <= 1'b0;
          end else begin
            cyc_reg <= cyc_reg - CYC_ONE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            if (edge_reg == CNT_MAX) ovf_flag_reg <= 1'b1;
            else                     edge_reg     <= edge_reg + CNT_ONE;
          end
          if (cyc_reg == CYC_ONE) state_reg <= ST_DONE;
          else                    cyc_reg   <= cyc_reg - CYC_ONE;
        end
        ST_DONE: begin
          count_reg    <= edge_reg;
          ovf_reg      <= ovf_flag_reg;
          valid_reg    <= 1'b1;
          osc_init_reg <= 1'b1;
          state_reg    <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign OSC_INIT  = osc_init_reg;
  assign bus.busy  = (state_reg == ST_SETTLE) | (state_reg == ST_MEASURE);
  assign bus.valid = valid_reg;
  assign bus.count = count_reg;
  assign bus.ovf   = ovf_reg;

endmodule
